// File: rtl/devtbl_seq.sv
// devtbl_seq: device table for the pi1 slave port.
// It maps the first RAM device at 0x1000. A sequential scanner computes the
// block's own map size, one table entry per cycle, and can be re-run. The
// block also provides INFO registers and a timed reset-request sequencer.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-low reset
//   rescan_i                pulse that restarts the map-size scan
//   rst0_o, rst1_o          reset-request pair, held for RSTHOLD cycles
//   rst2_o                  one-cycle RRESET pulse
//   scanerr_o               map-size underflow seen in the last scan
//   pi1_*                   pi1 slave port (op, addr, data, sel, rdy, mapsz)
//   devtbl_*_flat_i         per-device id / map size / interrupt use, flattened
//
// state | meaning
// SCAN  | walking the table from idx 2 and subtracting map sizes; port not ready
// IDLE  | map size valid; pi1 ops accepted
module devtbl_seq #(
  parameter int ARCHBITSZ  = 32,
  parameter int RAMCACHESZ = 2,
  parameter int PRELDRADDR = 0,
  parameter int DEVMAPCNT  = 2,
  parameter int SOCID      = 0,
  parameter int RSTHOLD    = 16,
  parameter int SOCVERSION = 1,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           rescan_i,
  output logic                           rst0_o,
  output logic                           rst1_o,
  output logic                           rst2_o,
  output logic                           scanerr_o,
  input  logic [1:0]                     pi1_op_i,
  input  logic [ADDRBITSZ-1:0]           pi1_addr_i,
  input  logic [ARCHBITSZ-1:0]           pi1_data_i,
  output logic [ARCHBITSZ-1:0]           pi1_data_o,
  input  logic [ARCHBITSZ/8-1:0]         pi1_sel_i,
  output logic                           pi1_rdy_o,
  output logic [ADDRBITSZ-1:0]           pi1_mapsz_o,
  input  logic [ARCHBITSZ*DEVMAPCNT-1:0] devtbl_id_flat_i,
  input  logic [ADDRBITSZ*DEVMAPCNT-1:0] devtbl_mapsz_flat_i,
  input  logic [DEVMAPCNT-1:0]           devtbl_useintr_flat_i
);

  localparam int BYTESZ = ARCHBITSZ / 8;
  localparam int LOGB   = $clog2(BYTESZ);
  localparam int BLKSZ  = 512 / BYTESZ;
  localparam int BASE   = 4096 / BYTESZ - BLKSZ;
  localparam int IDXW   = $clog2(DEVMAPCNT + 3);
  localparam int HOLDW  = $clog2(RSTHOLD + 1);
  localparam int A2W    = ADDRBITSZ - 1;

  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_RW = 2'b11;

  // The table must leave room for the block device inside the 0x1000 window.
  if (DEVMAPCNT > (3584 / BYTESZ) - 1) begin : g_bad_devmapcnt
    $fatal(1, "devtbl_seq: DEVMAPCNT too large");
  end

  typedef enum logic {ST_SCAN = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [ADDRBITSZ-1:0]   acc_q, acc_d;
  logic [ADDRBITSZ-1:0]   mapsz_q, mapsz_d;
  logic                   scanerr_q, scanerr_d;
  logic [ARCHBITSZ-1:0]   data_q, data_d;
  logic                   rst0_q, rst0_d;
  logic                   rst1_q, rst1_d;
  logic                   rst2_q, rst2_d;
  logic                   rr_done_q, rr_done_d;
  logic [HOLDW-1:0]       hold_q, hold_d;

  logic                   scan_live;
  logic [ARCHBITSZ-1:0]   scan_id;
  logic [ADDRBITSZ-1:0]   scan_msz;
  logic [ARCHBITSZ-1:0]   rd_word;
  logic [ADDRBITSZ-1:0]   rd_msz;
  logic [ARCHBITSZ-1:0]   info_word;
  logic [A2W-1:0]         a2;
  logic                   restart;
  logic                   unused_sel;

  assign unused_sel = ^pi1_sel_i;
  assign a2         = pi1_addr_i[ADDRBITSZ-1:1];

  // Table entry at the scan index; scan_live is 0 once idx runs past the table.
  always_comb begin
    scan_live = 1'b0;
    scan_id   = '0;
    scan_msz  = '0;
    for (int i = 0; i < DEVMAPCNT; i++) begin
      if (idx_q == IDXW'(i)) begin
        scan_live = 1'b1;
        scan_id   = devtbl_id_flat_i[i*ARCHBITSZ +: ARCHBITSZ];
        scan_msz  = devtbl_mapsz_flat_i[i*ADDRBITSZ +: ADDRBITSZ];
      end
    end
  end

  // Read word: even address -> id, odd -> map size in the upper bits plus useintr.
  // Entry 0 is this block itself (512B), entry 1 is the scanned own map size.
  always_comb begin
    rd_word = '0;
    rd_msz  = '0;
    for (int i = 0; i < DEVMAPCNT; i++) begin
      if (a2 == A2W'(i)) begin
        if (!pi1_addr_i[0]) begin
          rd_word = devtbl_id_flat_i[i*ARCHBITSZ +: ARCHBITSZ];
        end else begin
          if (i == 0)      rd_msz = ADDRBITSZ'(BLKSZ);
          else if (i == 1) rd_msz = mapsz_q;
          else             rd_msz = devtbl_mapsz_flat_i[i*ADDRBITSZ +: ADDRBITSZ];
          rd_word = (ARCHBITSZ'(rd_msz) << LOGB) | ARCHBITSZ'(devtbl_useintr_flat_i[i]);
        end
      end
    end
  end

  always_comb begin
    case (pi1_data_i)
      ARCHBITSZ'(0): info_word = ARCHBITSZ'(SOCVERSION);
      ARCHBITSZ'(1): info_word = ARCHBITSZ'(RAMCACHESZ);
      ARCHBITSZ'(2): info_word = ARCHBITSZ'({rst1_q, rst0_q});
      ARCHBITSZ'(3): info_word = rr_done_q ? '0 : ARCHBITSZ'(PRELDRADDR);
      ARCHBITSZ'(4): info_word = ARCHBITSZ'(SOCID);
      ARCHBITSZ'(5): info_word = ARCHBITSZ'(DEVMAPCNT);
      ARCHBITSZ'(6): info_word = ARCHBITSZ'({scanerr_q, state_q == ST_IDLE});
      default:       info_word = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    mapsz_d   = mapsz_q;
    scanerr_d = scanerr_q;
    data_d    = data_q;
    rst0_d    = rst0_q;
    rst1_d    = rst1_q;
    rst2_d    = 1'b0;
    rr_done_d = rr_done_q;
    hold_d    = hold_q;
    restart   = rescan_i;

    if (hold_q != '0) begin
      hold_d = hold_q - HOLDW'(1);
      if (hold_q == HOLDW'(1)) begin
        rst0_d = 1'b0;
        rst1_d = 1'b0;
      end
    end

    if (state_q == ST_IDLE) begin
      case (pi1_op_i)
        OP_RD: data_d = rd_word;
        OP_RW: begin
          if (pi1_addr_i == ADDRBITSZ'(0)) begin
            data_d = info_word;
          end else if (pi1_addr_i == ADDRBITSZ'(1)) begin
            data_d = '0;
            case (pi1_data_i)
              ARCHBITSZ'(0): begin rst1_d = 1'b0; rst0_d = 1'b1; hold_d = HOLDW'(RSTHOLD); end
              ARCHBITSZ'(1): begin rst1_d = 1'b1; rst0_d = 1'b0; hold_d = HOLDW'(RSTHOLD); end
              ARCHBITSZ'(2): begin rst1_d = 1'b1; rst0_d = 1'b1; hold_d = HOLDW'(RSTHOLD); end
              ARCHBITSZ'(3): begin rst2_d = 1'b1; rr_done_d = 1'b1; restart = 1'b1; end
              default: ;
            endcase
          end else begin
            data_d = '0;
          end
        end
        OP_WR:   ;
        default: ;
      endcase
    end

    case (state_q)
      ST_SCAN: begin
        if (scan_live && scan_id != ARCHBITSZ'(1)) begin
          // Borrow check: clamp at zero and flag, but keep walking the table.
          if (acc_q < scan_msz) begin
            acc_d     = '0;
            scanerr_d = 1'b1;
          end else begin
            acc_d = acc_q - scan_msz;
          end
          idx_d = idx_q + IDXW'(1);
        end else begin
          mapsz_d = acc_q;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (restart) begin
      state_d   = ST_SCAN;
      idx_d     = IDXW'(2);
      acc_d     = ADDRBITSZ'(BASE);
      scanerr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_SCAN;
      idx_q     <= IDXW'(2);
      acc_q     <= ADDRBITSZ'(BASE);
      mapsz_q   <= '0;
      scanerr_q <= 1'b0;
      data_q    <= '0;
      rst0_q    <= 1'b0;
      rst1_q    <= 1'b0;
      rst2_q    <= 1'b0;
      rr_done_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      mapsz_q   <= mapsz_d;
      scanerr_q <= scanerr_d;
      data_q    <= data_d;
      rst0_q    <= rst0_d;
      rst1_q    <= rst1_d;
      rst2_q    <= rst2_d;
      rr_done_q <= rr_done_d;
      hold_q    <= hold_d;
    end
  end

  assign pi1_rdy_o   = (state_q == ST_IDLE);
  assign pi1_mapsz_o = mapsz_q;
  assign pi1_data_o  = data_q;
  assign scanerr_o   = scanerr_q;
  assign rst0_o      = rst0_q;
  assign rst1_o      = rst1_q;
  assign rst2_o      = rst2_q;

endmodule

// File: tb/tb_devtbl_seq.sv
module tb_devtbl_seq;

  localparam int ARCHBITSZ = 32;
  localparam int ADDRBITSZ = 30;
  localparam int DEVMAPCNT = 4;

  logic                           clk_i = 1'b0;
  logic                           rst_i = 1'b0;
  logic                           rescan_i = 1'b0;
  logic                           rst0_o, rst1_o, rst2_o, scanerr_o;
  logic [1:0]                     pi1_op_i = 2'b00;
  logic [ADDRBITSZ-1:0]           pi1_addr_i = '0;
  logic [ARCHBITSZ-1:0]           pi1_data_i = '0;
  logic [ARCHBITSZ-1:0]           pi1_data_o;
  logic [3:0]                     pi1_sel_i = 4'hf;
  logic                           pi1_rdy_o;
  logic [ADDRBITSZ-1:0]           pi1_mapsz_o;
  logic [ARCHBITSZ*DEVMAPCNT-1:0] id_flat;
  logic [ADDRBITSZ*DEVMAPCNT-1:0] msz_flat;
  logic [DEVMAPCNT-1:0]           useintr = 4'b1010;
  logic [ADDRBITSZ-1:0]           ms2 = 30'd64;

  int n_tests = 0;
  int n_fail  = 0;

  assign id_flat  = {32'd1, 32'd5, 32'h22, 32'h11};
  assign msz_flat = {30'd30, ms2, 30'd20, 30'd10};

  always #5 clk_i = ~clk_i;

  devtbl_seq #(
    .ARCHBITSZ(32), .RAMCACHESZ(2), .PRELDRADDR('h4000), .DEVMAPCNT(4),
    .SOCID('h55), .RSTHOLD(4), .SOCVERSION(7)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rescan_i(rescan_i),
    .rst0_o(rst0_o), .rst1_o(rst1_o), .rst2_o(rst2_o), .scanerr_o(scanerr_o),
    .pi1_op_i(pi1_op_i), .pi1_addr_i(pi1_addr_i), .pi1_data_i(pi1_data_i),
    .pi1_data_o(pi1_data_o), .pi1_sel_i(pi1_sel_i), .pi1_rdy_o(pi1_rdy_o),
    .pi1_mapsz_o(pi1_mapsz_o),
    .devtbl_id_flat_i(id_flat), .devtbl_mapsz_flat_i(msz_flat),
    .devtbl_useintr_flat_i(useintr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic op1(input logic [1:0] op, input int addr, input int data);
    pi1_op_i   = op;
    pi1_addr_i = ADDRBITSZ'(addr);
    pi1_data_i = ARCHBITSZ'(data);
    tick();
    pi1_op_i   = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rdy", pi1_rdy_o, 0);
    chk("rst_mapsz", pi1_mapsz_o, 0);
    chk("rst_data", pi1_data_o, 0);
    chk("rst_pair", {rst2_o, rst1_o, rst0_o, scanerr_o}, 0);
    #3 rst_i = 1'b1;
    #1 chk("scan_rdy0", pi1_rdy_o, 0);
    tick();
    chk("scan_rdy1", pi1_rdy_o, 0);
    tick();
    chk("scan_done_rdy", pi1_rdy_o, 1);
    chk("scan_mapsz", pi1_mapsz_o, 832);

    // reads
    op1(2'b10, 3, 0);  chk("rd3", pi1_data_o, 3329);
    op1(2'b10, 9, 0);  chk("rd9", pi1_data_o, 0);
    op1(2'b10, 4, 0);  chk("rd4", pi1_data_o, 5);
    op1(2'b10, 5, 0);  chk("rd5", pi1_data_o, 256);
    op1(2'b10, 1, 0);  chk("rd1", pi1_data_o, 512);
    op1(2'b10, 7, 0);  chk("rd7", pi1_data_o, 121);
    op1(2'b10, 6, 0);  chk("rd6", pi1_data_o, 1);
    op1(2'b00, 0, 0);  chk("noop_hold", pi1_data_o, 1);
    op1(2'b01, 0, 5);  chk("wr_hold", pi1_data_o, 1);

    // INFO
    op1(2'b11, 0, 0);  chk("info0", pi1_data_o, 7);
    op1(2'b11, 0, 1);  chk("info1", pi1_data_o, 2);
    op1(2'b11, 0, 4);  chk("info4", pi1_data_o, 'h55);
    op1(2'b11, 0, 5);  chk("info5", pi1_data_o, 4);
    op1(2'b11, 0, 6);  chk("info6", pi1_data_o, 1);
    op1(2'b11, 0, 9);  chk("info9", pi1_data_o, 0);
    op1(2'b11, 0, 3);  chk("info3_pre", pi1_data_o, 'h4000);
    op1(2'b11, 5, 0);  chk("rw_other", pi1_data_o, 0);

    // CRESET hold
    op1(2'b11, 1, 2);
    chk("act_data0", pi1_data_o, 0);
    for (int k = 0; k < 4; k++) begin
      chk("creset_hold", {rst1_o, rst0_o}, 2'b11);
      tick();
    end
    chk("creset_drop", {rst1_o, rst0_o}, 2'b00);

    // WRESET override at hold=2
    op1(2'b11, 1, 2);
    tick();
    tick();
    op1(2'b11, 1, 1);
    for (int k = 0; k < 4; k++) begin
      chk("wreset_hold", {rst1_o, rst0_o}, 2'b10);
      tick();
    end
    chk("wreset_drop", {rst1_o, rst0_o}, 2'b00);

    // PWROFF, read back via INFO 2
    op1(2'b11, 1, 0);
    chk("pwroff", {rst1_o, rst0_o}, 2'b01);
    op1(2'b11, 0, 2);
    chk("info2", pi1_data_o, 1);
    repeat (4) tick();
    chk("pwroff_drop", {rst1_o, rst0_o}, 2'b00);

    // RRESET
    op1(2'b11, 1, 3);
    chk("rr_pulse", rst2_o, 1);
    chk("rr_rdy", pi1_rdy_o, 0);
    tick();
    chk("rr_pulse_end", rst2_o, 0);
    chk("rr_rdy1", pi1_rdy_o, 0);
    tick();
    chk("rr_rescan_done", {pi1_rdy_o, 2'b00, pi1_mapsz_o}, {1'b1, 2'b00, 30'd832});
    op1(2'b11, 0, 3);  chk("info3_post", pi1_data_o, 0);

    // underflow scan with a concurrent RD
    ms2 = 30'd900;
    rescan_i = 1'b1;
    op1(2'b10, 4, 0);
    rescan_i = 1'b0;
    chk("resc_rdy", pi1_rdy_o, 0);
    chk("resc_rd_accepted", pi1_data_o, 5);
    op1(2'b10, 6, 0);
    chk("scan_rd_ignored", pi1_data_o, 5);
    chk("uf_err_early", scanerr_o, 1);
    tick();
    chk("uf_mapsz", pi1_mapsz_o, 0);
    chk("uf_err", scanerr_o, 1);
    op1(2'b11, 0, 6);  chk("info6_err", pi1_data_o, 3);
    ms2 = 30'd64;
    rescan_i = 1'b1;
    tick();
    rescan_i = 1'b0;
    chk("err_cleared", scanerr_o, 0);
    tick();
    tick();
    chk("resc_mapsz", pi1_mapsz_o, 832);

    // rescan during SCAN restarts
    rescan_i = 1'b1;
    tick();
    tick();
    rescan_i = 1'b0;
    tick();
    chk("restart_rdy0", pi1_rdy_o, 0);
    tick();
    chk("restart_rdy1", pi1_rdy_o, 1);

    // async reset mid-SCAN and mid-hold
    op1(2'b11, 1, 2);
    rescan_i = 1'b1;
    op1(2'b10, 6, 0);
    rescan_i = 1'b0;
    chk("pre_rst_state", {pi1_rdy_o, rst1_o, rst0_o, pi1_data_o[0]}, 4'b0111);
    #3 rst_i = 1'b0;
    #1;
    chk("async_rst_pair", {rst2_o, rst1_o, rst0_o, scanerr_o}, 0);
    chk("async_rst_data", pi1_data_o, 0);
    chk("async_rst_mapsz", {pi1_rdy_o, pi1_mapsz_o}, 0);
    #2 rst_i = 1'b1;
    tick();
    chk("rerun_rdy0", pi1_rdy_o, 0);
    tick();
    chk("rerun_mapsz", {pi1_rdy_o, rst1_o, rst0_o, pi1_mapsz_o}, {3'b100, 30'd832});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
